imem_loader: RTL and testbench

Boot-time program loader: the write-side counterpart of the byte-addressed instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and writes each payload byte sequentially into the instruction memory's byte array from address 0. While loading, it holds the CPU in reset so that fetch never observes a partially written program.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the boot-time instruction memory loader.
// MEM_BYTES is the single source of truth for instruction memory capacity.
package imem_loader_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LEN_W     = 32;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_BYTES = 4;
    localparam int unsigned IDX_W     = $clog2(LEN_BYTES);
    localparam int unsigned MEM_BYTES = 2**16;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: stream input handshake, byte write port to imem, and status.
// The slave modport is the loader; the master modport is its environment.
interface imem_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = imem_loader_pkg::ADDR_W
);
    import imem_loader_pkg::*;

    logic                     start;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     cpu_hold;
    logic                     done;
    logic                     err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte stream loader: writes payload into imem from address 0
// while holding the CPU in reset until the whole program is in place.
module imem_loader #(
    parameter int unsigned ADDRESS_WIDTH = imem_loader_pkg::ADDR_W,
    parameter int unsigned MEM_BYTES     = imem_loader_pkg::MEM_BYTES
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    import imem_loader_pkg::*;

    loader_state_t            state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [LEN_W-1:0]         len_q, len_d, len_shift;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d;
    logic                     in_ready_q, in_ready_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     xfer;

    assign xfer = bus.in_valid && in_ready_q;

    // Next-state, length assembly, write port and status flags.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        len_shift = len_q;
        len_shift[DATA_W*idx_q +: DATA_W] = bus.in_data;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = LEN;
                    idx_d   = '0;
                    len_d   = '0;
                    cnt_d   = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    len_d = len_shift;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(LEN_BYTES - 1)) begin
                        if (len_shift == '0) begin
                            state_d = DONE;
                        end else if (len_shift > LEN_W'(MEM_BYTES)) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = bus.in_data;
                    cnt_d     = cnt_q + ADDRESS_WIDTH'(1);
                    if (cnt_q == ADDRESS_WIDTH'(len_q) - ADDRESS_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags follow the state being entered so they are plain flops.
        in_ready_d = (state_d == LEN) || (state_d == DATA);
        cpu_hold_d = (state_d == LEN) || (state_d == DATA) || (state_d == ERR);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts the write
// sequence, and a per-cycle monitor checks every write and flag invariant.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned AW = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDRESS_WIDTH(AW)) bus();

    imem_loader #(.ADDRESS_WIDTH(AW), .MEM_BYTES(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  checks = 0;
    int  errors = 0;
    int  hold_cycles = 0;
    bit  mon_en = 1'b0;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: each write must be the next one the model predicted.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cpu_hold === 1'b1) hold_cycles++;
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, mon_e.addr);
                    check("wr_data", bus.wr_data, mon_e.data);
                end
            end
            check("ready_implies_hold", bus.in_ready & ~bus.cpu_hold, 0);
            check("done_err_exclusive", bus.done & bus.err, 0);
        end
    end

    // Stream-level model: payload byte i lands at address i when 0 < N <= capacity.
    function automatic void model_load(input bq_t bytes);
        logic [31:0] n;
        wr_t w;
        n = {bytes[3], bytes[2], bytes[1], bytes[0]};
        if (n != 0 && n <= MEM_BYTES) begin
            for (int i = 0; i < int'(n); i++) begin
                w.addr = AW'(i);
                w.data = bytes[4 + i];
                exp_q.push_back(w);
            end
        end
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ready", bus.in_ready, 1);
        check("start_done_clr", bus.done, 0);
        check("start_err_clr", bus.err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit strt);
        int n = 0;
        bit took = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.start    = strt;
        while (!took && n < 20) begin
            took = (bus.in_ready === 1'b1);
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready low for 20 cycles expected a transfer");
        end
    endtask

    task automatic stream(input bq_t bytes, input bit gap, input int start_at, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(bytes[i], i == start_at);
            if (gap && i < nbytes - 1) @(negedge clk);
        end
    endtask

    task automatic run_load(input bq_t bytes, input bit gap, input int start_at);
        model_load(bytes);
        pulse_start();
        stream(bytes, gap, start_at, bytes.size());
    endtask

    task automatic check_final_write(input string tag, input logic [AW-1:0] addr, input logic [7:0] data);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_hold"}, bus.cpu_hold, 0);
        check({tag, "_wr_en"}, bus.wr_en, 1);
        check({tag, "_addr"}, bus.wr_addr, addr);
        check({tag, "_data"}, bus.wr_data, data);
        check({tag, "_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t prog, big, b;

        prog = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'h10, 8'h00};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_cpu_hold", bus.cpu_hold, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Normal load, valid held high; pin the model against hand values first.
        model_load(prog);
        check("model_size", exp_q.size(), 8);
        check("model_first", {exp_q[0].addr, exp_q[0].data}, {32'd0, 8'h13});
        check("model_third", {exp_q[2].addr, exp_q[2].data}, {32'd2, 8'hA0});
        check("model_last", {exp_q[7].addr, exp_q[7].data}, {32'd7, 8'h00});
        hold_cycles = 0;
        pulse_start();
        stream(prog, 1'b0, -1, prog.size());
        check_final_write("normal", 32'd7, 8'h00);
        @(negedge clk);
        check("normal_single_pulse", bus.wr_en, 0);
        check("normal_done_level", bus.done, 1);
        @(negedge clk);
        check("normal_hold_cycles", hold_cycles, 12);
        check("normal_drained", exp_q.size(), 0);

        // Same stream with in_valid toggling.
        run_load(prog, 1'b1, -1);
        check_final_write("gapped", 32'd7, 8'h00);
        repeat (2) @(negedge clk);
        check("gapped_drained", exp_q.size(), 0);

        // Zero length: DONE right after the 4th length byte, no writes.
        b = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(b, 1'b0, -1);
        check("zero_done", bus.done, 1);
        check("zero_wr_en", bus.wr_en, 0);
        check("zero_hold", bus.cpu_hold, 0);
        @(negedge clk);
        check("zero_ready_after", bus.in_ready, 0);

        // Full-capacity load: last write at 0xFFFF.
        big = '{8'h00, 8'h00, 8'h01, 8'h00};
        for (int i = 0; i < int'(MEM_BYTES); i++) big.push_back(8'(i * 7 + 3));
        run_load(big, 1'b0, -1);
        check_final_write("full", 32'h0000FFFF, 8'(32'hFFFF * 7 + 3));
        repeat (2) @(negedge clk);
        check("full_drained", exp_q.size(), 0);

        // One byte over capacity: ERR, payload never consumed.
        b = '{8'h01, 8'h00, 8'h01, 8'h00};
        run_load(b, 1'b0, -1);
        check("over_err", bus.err, 1);
        check("over_hold", bus.cpu_hold, 1);
        check("over_ready", bus.in_ready, 0);
        check("over_done", bus.done, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check("over_still_err", bus.err, 1);
        check("over_still_blocked", bus.in_ready, 0);
        check("over_no_writes", exp_q.size(), 0);

        // Reset after 3 of 5 payload bytes, with a byte offered during reset.
        b = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        model_load(b);
        pulse_start();
        stream(b, 1'b0, -1, 7);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA4;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_wr_addr", bus.wr_addr, 0);
        check("midrst_wr_data", bus.wr_data, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_cpu_hold", bus.cpu_hold, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_err", bus.err, 0);
        check("midrst_pending", exp_q.size(), 2);
        exp_q.delete();
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3};
        run_load(b, 1'b0, -1);
        check_final_write("reload", 32'd1, 8'hC3);
        repeat (2) @(negedge clk);
        check("reload_drained", exp_q.size(), 0);

        // start during DATA is ignored; start in DONE begins a new load.
        run_load(prog, 1'b0, 6);
        check_final_write("ignored_start", 32'd7, 8'h00);
        @(negedge clk);
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h77};
        run_load(b, 1'b0, -1);
        check_final_write("restart", 32'd0, 8'h77);
        repeat (2) @(negedge clk);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
